// File: rtl/pll_reset_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_pkg
// Description : Shared types and constants for the PLL reset sequencer:
//               state encoding, default parameter values and a counter
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_reset_pkg;

   // Sequencer state, 2-bit encoding
   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2
   } state_t;

   // Defaults for the 6 MHz core clock domain
   localparam int C_SYNC_STAGES = 2;
   localparam int C_LOCK_FILTER = 16;
   localparam int C_HOLD_CYCLES = 1024;
   localparam int C_CPU_DIV     = 4;      // 6 MHz / 4    = 1.5 MHz
   localparam int C_IRQ_DIV     = 2048;   // 6 MHz / 2048 ~ 2.93 kHz

   // Bits needed for a counter running 0 .. n-1; never narrower than 1
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : N-stage single-bit synchronizer with synchronous active-low
//               clear. Also used for the button inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
   parameter int STAGES = 2           // at least 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   // Shift the asynchronous input through the flop chain; clear on reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_seq
// Description : Qualifies the core PLL lock, holds the core in reset for a
//               fixed time after lock, and generates the CPU and IRQ-timer
//               clock enables. No enable pulses are produced outside RUN.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_seq
   import pll_reset_pkg::*;
#(
   parameter int SYNC_STAGES = C_SYNC_STAGES,  // at least 2
   parameter int LOCK_FILTER = C_LOCK_FILTER,
   parameter int HOLD_CYCLES = C_HOLD_CYCLES,
   parameter int CPU_DIV     = C_CPU_DIV,      // power of two, at least 2
   parameter int IRQ_DIV     = C_IRQ_DIV       // power of two, multiple of CPU_DIV
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       soft_req,
   output logic       core_reset_n,
   output logic       ena_cpu,
   output logic       ena_irq,
   output logic [7:0] lock_drops
);

   localparam int C_FILT_W = cnt_width(LOCK_FILTER);
   localparam int C_HOLD_W = cnt_width(HOLD_CYCLES);
   localparam int C_CPU_W  = cnt_width(CPU_DIV);
   localparam int C_DIV_W  = cnt_width(IRQ_DIV);

   localparam logic [C_FILT_W-1:0] C_FILT_LAST = C_FILT_W'(LOCK_FILTER - 1);
   localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [C_CPU_W-1:0]  C_CPU_LAST  = C_CPU_W'(CPU_DIV - 1);
   localparam logic [C_DIV_W-1:0]  C_IRQ_LAST  = C_DIV_W'(IRQ_DIV - 1);

   state_t              r_state;
   logic [C_FILT_W-1:0] r_filt_cnt;
   logic [C_HOLD_W-1:0] r_hold_cnt;
   logic [C_DIV_W-1:0]  r_div_cnt;
   logic [7:0]          r_lock_drops;
   logic                r_core_reset_n;
   logic                r_ena_cpu;
   logic                r_ena_irq;
   logic                w_lock_s;

   // pll_locked is asynchronous to clk; this is its only point of use
   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (pll_locked),
      .o_q   (w_lock_s)
   );

   // Lock filter, reset hold, enable divider and registered output decode.
   // Outputs decode the current state, so they trail the state by one edge
   // and an enable can never appear without core_reset_n already high.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= WAIT_LOCK;
         r_filt_cnt     <= '0;
         r_hold_cnt     <= '0;
         r_div_cnt      <= '0;
         r_lock_drops   <= '0;
         r_core_reset_n <= 1'b0;
         r_ena_cpu      <= 1'b0;
         r_ena_irq      <= 1'b0;
      end else begin
         r_core_reset_n <= (r_state == RUN);
         r_ena_cpu      <= (r_state == RUN) && (r_div_cnt[C_CPU_W-1:0] == C_CPU_LAST);
         r_ena_irq      <= (r_state == RUN) && (r_div_cnt == C_IRQ_LAST);

         case (r_state)
            WAIT_LOCK: begin
               if (!w_lock_s) begin
                  r_filt_cnt <= '0;
               end else if (r_filt_cnt == C_FILT_LAST) begin
                  r_state    <= HOLD;
                  r_hold_cnt <= '0;
                  r_filt_cnt <= '0;
               end else begin
                  r_filt_cnt <= r_filt_cnt + C_FILT_W'(1);
               end
            end

            HOLD: begin
               if (!w_lock_s) begin
                  r_state    <= WAIT_LOCK;
                  r_filt_cnt <= '0;
               end else if (soft_req) begin
                  // A held soft request parks the block here indefinitely
                  r_hold_cnt <= '0;
               end else if (r_hold_cnt == C_HOLD_LAST) begin
                  r_state   <= RUN;
                  r_div_cnt <= '0;
               end else begin
                  r_hold_cnt <= r_hold_cnt + C_HOLD_W'(1);
               end
            end

            RUN: begin
               if (!w_lock_s) begin
                  r_state    <= WAIT_LOCK;
                  r_filt_cnt <= '0;
                  if (r_lock_drops != 8'hFF) begin
                     r_lock_drops <= r_lock_drops + 8'd1;
                  end
               end else if (soft_req) begin
                  r_state    <= HOLD;
                  r_hold_cnt <= '0;
               end else if (r_div_cnt == C_IRQ_LAST) begin
                  r_div_cnt <= '0;
               end else begin
                  r_div_cnt <= r_div_cnt + C_DIV_W'(1);
               end
            end

            default: begin
               r_state    <= WAIT_LOCK;
               r_filt_cnt <= '0;
            end
         endcase
      end
   end

   assign core_reset_n = r_core_reset_n;
   assign ena_cpu      = r_ena_cpu;
   assign ena_irq      = r_ena_irq;
   assign lock_drops   = r_lock_drops;

endmodule
`default_nettype wire
